// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the Data_Memory line port between icache (p0) and dcache (p1).
// Define MEM_ARB_ROUND_ROBIN_EN to break ties by alternating owners instead of fixed p1 priority.
module mem_arbiter #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p0_enable_i,
   input  logic              p0_write_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [DATA_W-1:0] p0_data_i,
   output logic              p0_ack_o,
   output logic [DATA_W-1:0] p0_data_o,
   input  logic              p1_enable_i,
   input  logic              p1_write_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [DATA_W-1:0] p1_data_i,
   output logic              p1_ack_o,
   output logic [DATA_W-1:0] p1_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [1:0]        grant_o,
   output logic              busy_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t     state;
   logic       last_grant;
   logic [1:0] grant_q;
   logic       p1_wins;

   // With round robin, a tie goes to whichever port did not own the last transaction.
   always_comb begin
      p1_wins = p1_enable_i && (!p0_enable_i || !RR || !last_grant);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         last_grant <= 1'b0;
         grant_q    <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (p1_wins) begin
                  state   <= GNT1;
                  grant_q <= 2'b10;
               end else if (p0_enable_i) begin
                  state   <= GNT0;
                  grant_q <= 2'b01;
               end
            end
            GNT0: begin
               if (mem_ack_i) begin
                  state      <= IDLE;
                  last_grant <= 1'b0;
                  grant_q    <= 2'b00;
               end
            end
            GNT1: begin
               if (mem_ack_i) begin
                  state      <= IDLE;
                  last_grant <= 1'b1;
                  grant_q    <= 2'b00;
               end
            end
            default: begin
               state   <= IDLE;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

   assign grant_o      = grant_q;
   assign busy_o       = (state != IDLE);
   assign mem_enable_o = (state != IDLE);

   // Memory side follows the owner's live inputs, even if it has dropped its request early.
   always_comb begin
      mem_write_o = 1'b0;
      mem_addr_o  = '0;
      mem_data_o  = '0;
      if (state == GNT0) begin
         mem_write_o = p0_write_i;
         mem_addr_o  = p0_addr_i;
         mem_data_o  = p0_data_i;
      end else if (state == GNT1) begin
         mem_write_o = p1_write_i;
         mem_addr_o  = p1_addr_i;
         mem_data_o  = p1_data_i;
      end
   end

   // An ack coinciding with reset is swallowed rather than forwarded.
   assign p0_ack_o  = (state == GNT0) && mem_ack_i && !rst_i;
   assign p1_ack_o  = (state == GNT1) && mem_ack_i && !rst_i;
   assign p0_data_o = p0_ack_o ? mem_data_i : '0;
   assign p1_data_o = p1_ack_o ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
   localparam int DATA_W = 256;
   localparam int ADDR_W = 32;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
   logic [ADDR_W-1:0] p0_addr_i, p1_addr_i;
   logic [DATA_W-1:0] p0_data_i, p1_data_i;
   logic              p0_ack_o, p1_ack_o;
   logic [DATA_W-1:0] p0_data_o, p1_data_o;
   logic              mem_enable_o, mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_data_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_data_i;
   logic [1:0]        grant_o;
   logic              busy_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
      .p0_data_i(p0_data_i), .p0_ack_o(p0_ack_o), .p0_data_o(p0_data_o),
      .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
      .p1_data_i(p1_data_i), .p1_ack_o(p1_ack_o), .p1_data_o(p1_data_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
      .grant_o(grant_o), .busy_o(busy_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      p0_enable_i = 0; p0_write_i = 0; p0_addr_i = '0; p0_data_i = '0;
      p1_enable_i = 0; p1_write_i = 0; p1_addr_i = '0; p1_data_i = '0;
      mem_ack_i = 0; mem_data_i = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_i = 1;
      tick(); tick();
      rst_i = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_i = 1; p1_enable_i = 1; mem_ack_i = 1; p1_addr_i = 32'h40;
      tick(); tick();
      @(negedge clk_i);
      n_cmp++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL reset_grant got %b exp 00", grant_o); end
      n_cmp++; if ({mem_enable_o, mem_write_o, busy_o} !== 3'b000) begin n_err++; $display("FAIL reset_ctl got %b exp 000", {mem_enable_o, mem_write_o, busy_o}); end
      n_cmp++; if ({p0_ack_o, p1_ack_o} !== 2'b00) begin n_err++; $display("FAIL reset_ack got %b exp 00", {p0_ack_o, p1_ack_o}); end
      n_cmp++; if (mem_addr_o !== '0) begin n_err++; $display("FAIL reset_addr got %h exp 0", mem_addr_o); end
      rst_i = 0; p1_enable_i = 0; mem_ack_i = 0;
      tick();
   endtask

   task automatic test_single_read();
      logic [DATA_W-1:0] pat = {32{8'hA5}};
      do_reset();
      p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h0000_0100;
      @(negedge clk_i);
      n_cmp++; if (mem_enable_o !== 1'b0) begin n_err++; $display("FAIL single_c0_en got %b exp 0", mem_enable_o); end
      tick();
      @(negedge clk_i);
      n_cmp++; if (grant_o !== 2'b01) begin n_err++; $display("FAIL single_grant got %b exp 01", grant_o); end
      n_cmp++; if ({mem_enable_o, mem_write_o, busy_o} !== 3'b101) begin n_err++; $display("FAIL single_ctl got %b exp 101", {mem_enable_o, mem_write_o, busy_o}); end
      n_cmp++; if (mem_addr_o !== 32'h100) begin n_err++; $display("FAIL single_addr got %h exp 100", mem_addr_o); end
      for (int c = 2; c < 10; c++) begin
         tick();
         @(negedge clk_i);
         n_cmp++; if (p0_ack_o !== 1'b0) begin n_err++; $display("FAIL single_early_ack c%0d got %b exp 0", c, p0_ack_o); end
      end
      tick();
      mem_ack_i = 1; mem_data_i = pat;
      @(negedge clk_i);
      n_cmp++; if ({p0_ack_o, p1_ack_o} !== 2'b10) begin n_err++; $display("FAIL single_ack got %b exp 10", {p0_ack_o, p1_ack_o}); end
      n_cmp++; if (p0_data_o !== pat) begin n_err++; $display("FAIL single_data got %h exp %h", p0_data_o, pat); end
      tick();
      mem_ack_i = 0; p0_enable_i = 0;
      @(negedge clk_i);
      n_cmp++; if ({mem_enable_o, p0_ack_o} !== 2'b00) begin n_err++; $display("FAIL single_after got %b exp 00", {mem_enable_o, p0_ack_o}); end
      n_cmp++; if (p0_data_o !== '0) begin n_err++; $display("FAIL single_data_idle got %h exp 0", p0_data_o); end
   endtask

   task automatic test_priority();
      do_reset();
      p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h200;
      p1_enable_i = 1; p1_write_i = 1; p1_addr_i = 32'h400; p1_data_i = 256'h1;
      tick();
      @(negedge clk_i);
      n_cmp++; if (grant_o !== 2'b10) begin n_err++; $display("FAIL prio_grant1 got %b exp 10", grant_o); end
      n_cmp++; if ({mem_write_o, mem_addr_o} !== {1'b1, 32'h400}) begin n_err++; $display("FAIL prio_req1 got %b/%h exp 1/400", mem_write_o, mem_addr_o); end
      n_cmp++; if (mem_data_o !== 256'h1) begin n_err++; $display("FAIL prio_wdata got %h exp 1", mem_data_o); end
      tick();
      mem_ack_i = 1;
      @(negedge clk_i);
      n_cmp++; if ({p0_ack_o, p1_ack_o} !== 2'b01) begin n_err++; $display("FAIL prio_ack1 got %b exp 01", {p0_ack_o, p1_ack_o}); end
      tick();
      mem_ack_i = 0; p1_enable_i = 0;
      @(negedge clk_i);
      n_cmp++; if ({mem_enable_o, grant_o} !== 3'b000) begin n_err++; $display("FAIL prio_gap got %b exp 000", {mem_enable_o, grant_o}); end
      tick();
      @(negedge clk_i);
      n_cmp++; if ({grant_o, mem_write_o, mem_addr_o} !== {2'b01, 1'b0, 32'h200}) begin n_err++; $display("FAIL prio_req2 got %b/%b/%h exp 01/0/200", grant_o, mem_write_o, mem_addr_o); end
      mem_ack_i = 1;
      @(posedge clk_i);
      n_cmp++; if ({p0_ack_o, p1_ack_o} !== 2'b10) begin n_err++; $display("FAIL prio_ack2 got %b exp 10", {p0_ack_o, p1_ack_o}); end
      #1;
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp;
      int k;
      do_reset();
      p0_enable_i = 1; p0_addr_i = 32'h200;
      p1_enable_i = 1; p1_write_i = 1; p1_addr_i = 32'h400;
      for (int i = 0; i < 4; i++) begin
         exp = (RR && (i % 2 == 1)) ? 2'b01 : 2'b10;
         k = 0;
         @(negedge clk_i);
         while (!mem_enable_o && k < 10) begin
            tick(); @(negedge clk_i); k++;
         end
         n_cmp++; if (grant_o !== exp) begin n_err++; $display("FAIL b2b_grant%0d got %b exp %b", i, grant_o, exp); end
         mem_ack_i = 1;
         tick();
         mem_ack_i = 0;
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      p1_enable_i = 1; p1_write_i = 1; p1_addr_i = 32'h300; p1_data_i = 256'hBEEF;
      tick();
      repeat (4) tick();
      rst_i = 1; mem_ack_i = 1; mem_data_i = 256'h77;
      @(negedge clk_i);
      n_cmp++; if (p1_ack_o !== 1'b0) begin n_err++; $display("FAIL rstmid_ack got %b exp 0", p1_ack_o); end
      tick();
      rst_i = 0; mem_ack_i = 0; p1_enable_i = 0;
      @(negedge clk_i);
      n_cmp++; if ({grant_o, mem_enable_o, mem_write_o, busy_o, p0_ack_o, p1_ack_o} !== 7'b0) begin n_err++; $display("FAIL rstmid_ctl got %b exp 0000000", {grant_o, mem_enable_o, mem_write_o, busy_o, p0_ack_o, p1_ack_o}); end
      n_cmp++; if ({mem_addr_o, mem_data_o, p1_data_o} !== '0) begin n_err++; $display("FAIL rstmid_bus got %h/%h/%h exp 0", mem_addr_o, mem_data_o, p1_data_o); end
   endtask

   task automatic test_stray_ack();
      do_reset();
      mem_ack_i = 1; mem_data_i = 256'h55;
      @(negedge clk_i);
      n_cmp++; if ({p0_ack_o, p1_ack_o, grant_o} !== 4'b0) begin n_err++; $display("FAIL stray_ack got %b exp 0000", {p0_ack_o, p1_ack_o, grant_o}); end
      tick();
      mem_ack_i = 0;
      @(negedge clk_i);
      n_cmp++; if ({busy_o, grant_o} !== 3'b0) begin n_err++; $display("FAIL stray_state got %b exp 000", {busy_o, grant_o}); end
   endtask

   task automatic test_early_drop();
      do_reset();
      p0_enable_i = 1; p0_addr_i = 32'h500;
      tick();
      repeat (3) tick();
      p0_enable_i = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         n_cmp++; if ({grant_o, mem_enable_o, mem_addr_o} !== {2'b01, 1'b1, 32'h500}) begin n_err++; $display("FAIL drop_hold%0d got %b/%b/%h exp 01/1/500", c, grant_o, mem_enable_o, mem_addr_o); end
         tick();
      end
      mem_ack_i = 1; mem_data_i = 256'h1234;
      @(negedge clk_i);
      n_cmp++; if ({p0_ack_o, p0_data_o} !== {1'b1, 256'h1234}) begin n_err++; $display("FAIL drop_ack got %b/%h exp 1/1234", p0_ack_o, p0_data_o); end
      tick();
      mem_ack_i = 0;
      @(negedge clk_i);
      n_cmp++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL drop_release got %b exp 00", grant_o); end
   endtask

   task automatic new_req(input int p);
      logic [DATA_W-1:0] d;
      d = {8{$urandom()}};
      if (p == 0) begin
         p0_enable_i = 1; p0_write_i = 1'($urandom_range(0, 1)); p0_addr_i = $urandom(); p0_data_i = d;
      end else begin
         p1_enable_i = 1; p1_write_i = 1'($urandom_range(0, 1)); p1_addr_i = $urandom(); p1_data_i = d;
      end
   endtask

   // Model: owner is -1 (free) or the port number; transactions end on ack and always pass through a free cycle.
   task automatic test_random();
      int owner = -1;
      int done = -1;
      int lastg = 0;
      logic              e_en, e_wr;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wd, e_d0, e_d1;
      logic [1:0]        e_gnt, e_ack;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (done == 0) begin p0_enable_i = 0; if ($urandom_range(0, 1) == 1) new_req(0); end
         if (done == 1) begin p1_enable_i = 0; if ($urandom_range(0, 1) == 1) new_req(1); end
         if (done != 0 && !p0_enable_i && $urandom_range(0, 3) == 0) new_req(0);
         if (done != 1 && !p1_enable_i && $urandom_range(0, 3) == 0) new_req(1);
         mem_ack_i = ($urandom_range(0, 3) == 0);
         mem_data_i = {8{$urandom()}};
         e_en = (owner >= 0);
         e_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
         e_wr = (owner == 0) ? p0_write_i : (owner == 1) ? p1_write_i : 1'b0;
         e_addr = (owner == 0) ? p0_addr_i : (owner == 1) ? p1_addr_i : '0;
         e_wd = (owner == 0) ? p0_data_i : (owner == 1) ? p1_data_i : '0;
         e_ack = {owner == 1 && mem_ack_i, owner == 0 && mem_ack_i};
         e_d0 = e_ack[0] ? mem_data_i : '0;
         e_d1 = e_ack[1] ? mem_data_i : '0;
         @(negedge clk_i);
         n_cmp++; if ({grant_o, busy_o, mem_enable_o} !== {e_gnt, e_en, e_en}) begin n_err++; $display("FAIL rnd_ctl c%0d got %b exp %b", c, {grant_o, busy_o, mem_enable_o}, {e_gnt, e_en, e_en}); end
         n_cmp++; if ({mem_write_o, mem_addr_o} !== {e_wr, e_addr}) begin n_err++; $display("FAIL rnd_req c%0d got %b/%h exp %b/%h", c, mem_write_o, mem_addr_o, e_wr, e_addr); end
         n_cmp++; if (mem_data_o !== e_wd) begin n_err++; $display("FAIL rnd_wdata c%0d got %h exp %h", c, mem_data_o, e_wd); end
         n_cmp++; if ({p1_ack_o, p0_ack_o} !== e_ack) begin n_err++; $display("FAIL rnd_ack c%0d got %b exp %b", c, {p1_ack_o, p0_ack_o}, e_ack); end
         n_cmp++; if ({p0_data_o, p1_data_o} !== {e_d0, e_d1}) begin n_err++; $display("FAIL rnd_rdata c%0d got %h/%h exp %h/%h", c, p0_data_o, p1_data_o, e_d0, e_d1); end
         done = -1;
         if (owner >= 0) begin
            if (mem_ack_i) begin
               lastg = owner; done = owner; owner = -1;
            end
         end else if (p0_enable_i && p1_enable_i) begin
            owner = (RR && lastg == 1) ? 0 : 1;
         end else if (p0_enable_i) begin
            owner = 0;
         end else if (p1_enable_i) begin
            owner = 1;
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      rst_i = 1;
      clear_inputs();
      test_reset();
      test_single_read();
      test_priority();
      test_back_to_back();
      test_reset_mid();
      test_stray_ack();
      test_early_drop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
